// File: rtl/ldpc_fp_pkg.sv
// Shared definitions for the LDPC floating-point check-node datapath:
// default field widths, the tracker state type and an all-ones magnitude helper.
package ldpc_fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } cn_state_t;

    // Returns a 64-bit word whose low (exp_w + man_w) bits are set; callers slice it.
    function automatic logic [63:0] mag_ones(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < exp_w + man_w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_mag_lt.sv
// Unsigned less-than on a floating-point magnitude {exp, man}; this ordering
// matches numeric order for non-negative IEEE-style values.
module fp_mag_lt #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] a,
    input  logic [EXP_W+MAN_W-1:0] b,
    output logic                   lt
);

    assign lt = (a < b);

endmodule

// File: rtl/fp_cn_min2_tracker.sv
// Streaming min-sum check-node front end: per row tracks min1/min2 magnitudes,
// index of min1 and sign parity. Optional input register stage: FP_CN_IN_PIPE_EN.
module fp_cn_min2_tracker
    import ldpc_fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF,
    parameter int unsigned DEG   = 6,
    parameter int unsigned IDX_W = $clog2(DEG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_min1,
    output logic [EXP_W+MAN_W-1:0] out_min2,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_sign,
    output logic                   out_trunc
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned MAG_W = EXP_W + MAN_W;
    localparam logic [63:0]        ONES_WIDE = mag_ones(EXP_W, MAN_W);
    localparam logic [MAG_W-1:0]   MAG_ONES  = ONES_WIDE[MAG_W-1:0];
    localparam logic [IDX_W-1:0]   LAST_POS  = IDX_W'(DEG - 1);

    cn_state_t          state;
    logic [MAG_W-1:0]   min1;
    logic [MAG_W-1:0]   min2;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   cnt;
    logic               sign;
    logic               trunc;

    // Beat presented to the compare logic, either straight from the port or staged.
    logic               p_valid;
    logic [W-1:0]       p_data;
    logic               p_last;

`ifdef FP_CN_IN_PIPE_EN
    logic               s_valid;
    logic [W-1:0]       s_data;
    logic               s_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
            s_last  <= 1'b0;
        end else begin
            s_valid <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                s_data <= in_data;
                s_last <= in_last;
            end
        end
    end

    // The staged beat always sits at position cnt, so it closes the row when
    // it is marked last or cnt has reached the degree limit.
    assign in_ready = rst_n && (state == ACC) && !(s_valid && (s_last || (cnt == LAST_POS)));
    assign p_valid  = s_valid;
    assign p_data   = s_data;
    assign p_last   = s_last;
`else
    assign in_ready = rst_n && (state == ACC);
    assign p_valid  = in_valid && in_ready;
    assign p_data   = in_data;
    assign p_last   = in_last;
`endif

    logic [MAG_W-1:0]   p_mag;
    logic               p_sign;
    logic               p_close;
    logic               lt_min1;
    logic               lt_min2;

    assign p_mag   = p_data[MAG_W-1:0];
    assign p_sign  = p_data[W-1];
    assign p_close = p_last || (cnt == LAST_POS);

    fp_mag_lt #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lt_min1 (
        .a  (p_mag),
        .b  (min1),
        .lt (lt_min1)
    );

    fp_mag_lt #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lt_min2 (
        .a  (p_mag),
        .b  (min2),
        .lt (lt_min2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            min1      <= MAG_ONES;
            min2      <= MAG_ONES;
            idx       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            trunc     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (p_valid) begin
                        if (lt_min1) begin
                            min2 <= min1;
                            min1 <= p_mag;
                            idx  <= cnt;
                        end else if (lt_min2) begin
                            min2 <= p_mag;
                        end
                        sign <= sign ^ p_sign;
                        cnt  <= cnt + 1'b1;
                        if (p_close) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            trunc     <= !p_last && (cnt == LAST_POS);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        min1      <= MAG_ONES;
                        min2      <= MAG_ONES;
                        idx       <= '0;
                        cnt       <= '0;
                        sign      <= 1'b0;
                        trunc     <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign out_min1  = min1;
    assign out_min2  = min2;
    assign out_idx   = idx;
    assign out_sign  = sign;
    assign out_trunc = trunc;

endmodule

// File: tb/tb_fp_cn_min2_tracker.sv
// Scoreboard bench for fp_cn_min2_tracker: directed rows plus random rows,
// each checked against a selection-based reference model.
module tb_fp_cn_min2_tracker;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int DEG   = 6;
    localparam int IDX_W = 3;
`ifdef FP_CN_IN_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [30:0] min1;
        logic [30:0] min2;
        logic [2:0]  idx;
        logic        sign;
        logic        trunc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] out_min1;
    logic [30:0] out_min2;
    logic [IDX_W-1:0] out_idx;
    logic        out_sign;
    logic        out_trunc;

    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   stall_req = 0;

    fp_cn_min2_tracker #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DEG(DEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min1  (out_min1),
        .out_min2  (out_min2),
        .out_idx   (out_idx),
        .out_sign  (out_sign),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference: min1 is the first-occurring smallest magnitude, min2 the smallest
    // magnitude among all other beats (all ones when there are none).
    function automatic res_t model(input logic [31:0] w[$], input bit last_flag);
        res_t r;
        int   mi;
        logic [31:0] wi;
        logic [31:0] wm;
        r = '0;
        r.min2 = '1;
        mi = 0;
        for (int i = 0; i < w.size(); i++) begin
            wi = w[i];
            wm = w[mi];
            r.sign = r.sign ^ wi[31];
            if (wi[30:0] < wm[30:0]) mi = i;
        end
        wm = w[mi];
        r.min1 = wm[30:0];
        r.idx  = 3'(mi);
        for (int i = 0; i < w.size(); i++) begin
            wi = w[i];
            if (i != mi && wi[30:0] < r.min2) r.min2 = wi[30:0];
        end
        r.trunc = (w.size() == DEG) && !last_flag;
        return r;
    endfunction

    task automatic send_row(input logic [31:0] w[$], input bit last_on_final, input bit do_push);
        bit acc;
        int tries;
        for (int i = 0; i < w.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = w[i];
                in_last  = (i == w.size() - 1) && last_on_final;
                acc      = in_ready;
                @(posedge clk);
                if (!acc) begin
                    tries++;
                    if (tries > 200) begin
                        total++;
                        bad++;
                        $display("FAIL accept_timeout: beat %0d never accepted, required acceptance within 200 cycles", i);
                        finish_run();
                    end
                end
            end
        end
        if (do_push) begin
            exp_q.push_back(model(w, last_on_final));
            #1;
            if (LAT == 0) begin
                check("latency_valid", 64'(out_valid), 64'd1);
            end else begin
                check("latency_early", 64'(out_valid), 64'd0);
                @(posedge clk);
                #1;
                check("latency_valid", 64'(out_valid), 64'd1);
            end
            check("in_ready_after_close", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: compares the presented result every cycle it is valid, which also
    // verifies stability under backpressure; pops on the handshake it schedules.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready = 1'b0;
                check("reset_in_ready", 64'(in_ready), 64'd0);
                check("reset_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                check("hold_in_ready", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got min1=%h with no result expected", out_min1);
                end else begin
                    e = exp_q[0];
                    check("min1", 64'(out_min1), 64'(e.min1));
                    check("min2", 64'(out_min2), 64'(e.min2));
                    check("idx", 64'(out_idx), 64'(e.idx));
                    check("sign", 64'(out_sign), 64'(e.sign));
                    check("trunc", 64'(out_trunc), 64'(e.trunc));
                end
                if (stall_req > 0) begin
                    stall_req--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                out_ready = $urandom_range(0, 1) != 0;
            end
        end
    end

    initial begin
        #2000000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        finish_run();
    end

    initial begin
        logic [31:0] row[$];
        logic [31:0] pool[4];
        int len;
        int waited;
        bit lf;
        pool[0] = 32'h3F800000;
        pool[1] = 32'hBF800000;
        pool[2] = 32'h00000000;
        pool[3] = 32'h7FFFFFFF;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_min1", 64'(out_min1), 64'h7FFFFFFF);
        check("rst_min2", 64'(out_min2), 64'h7FFFFFFF);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_sign", 64'(out_sign), 64'd0);
        check("rst_trunc", 64'(out_trunc), 64'd0);

        row = '{32'h3F800000, 32'hBF000000, 32'h40000000, 32'h3E800000};
        send_row(row, 1'b1, 1'b1);
        row = '{32'h3F800000, 32'h3F800000};
        send_row(row, 1'b1, 1'b1);
        row = '{32'hC0000000};
        send_row(row, 1'b1, 1'b1);
        row = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        send_row(row, 1'b0, 1'b1);
        row = '{32'h3F800000};
        send_row(row, 1'b1, 1'b1);

        stall_req = 5;
        row = '{32'h3F800000, 32'hBF000000, 32'h40000000, 32'h3E800000};
        send_row(row, 1'b1, 1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        row = '{32'h40400000, 32'h3E000000, 32'hC1000000};
        send_row(row, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        row = '{32'h3F000000};
        send_row(row, 1'b1, 1'b1);

        for (int r = 0; r < 60; r++) begin
            len = $urandom_range(1, DEG);
            lf  = (len < DEG) ? 1'b1 : ($urandom_range(0, 1) != 0);
            row.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) row.push_back(pool[$urandom_range(0, 3)]);
                else row.push_back($urandom);
            end
            send_row(row, lf, 1'b1);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        check("final_in_ready", 64'(in_ready), 64'd1);
        finish_run();
    end

endmodule

// File: doc/fp_cn_min2_tracker.md
# fp_cn_min2_tracker

Streaming min-sum check-node front end for the LDPC belief-propagation datapath. Accepts one signed floating-point variable-to-check message per beat and tracks, per row, the smallest and second-smallest magnitudes, the index of the smallest, and the XOR of all signs. Rows are closed by `in_last` or by reaching the degree limit. Results are presented on a valid/ready output port for the check-to-variable update stage.

## Interface
- `EXP_W`, 8: exponent width.
- `MAN_W`, 23: mantissa width; a word is `1+EXP_W+MAN_W` bits, with the sign in the MSB.
- `DEG`, 6: maximum row degree, ≥2.
- `IDX_W`, `$clog2(DEG)`: index width; derived, do not override.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts the beat.
- `in_data` in `1+EXP_W+MAN_W`: message {sign, exp, man}.
- `in_last` in 1: final beat of the row.
- `out_valid` out 1: row result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_min1` out `EXP_W+MAN_W`: smallest magnitude.
- `out_min2` out `EXP_W+MAN_W`: second-smallest magnitude.
- `out_idx` out `IDX_W`: beat position of min1 (0-based).
- `out_sign` out 1: XOR of all signs in the row.
- `out_trunc` out 1: row closed at DEG without `in_last`.

## Operation
- The magnitude is `{exp,man}`, compared as an unsigned integer. This is valid ordering for IEEE-style non-negative values. NaN and Inf are not special-cased; they are raw bit patterns.
- States: ACC and HOLD.
  - ACC: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- On an accepted beat with magnitude `m` at position `cnt`:
  - If `m < min1`: `min2←min1`, `min1←m`, `idx←cnt`.
  - Else if `m < min2`: `min2←m`.
  - Then `sign←sign^in_data[MSB]` and `cnt←cnt+1`.
- Ties use strict less-than, so the earlier position keeps min1. A value equal to min1 becomes min2 when it is below the current min2.
- Row close: an accepted beat with `in_last=1`, or an accepted beat at `cnt==DEG-1`.
  - Either condition moves ACC→HOLD.
  - `out_trunc=1` only if `cnt==DEG-1` and `in_last=0`.
- HOLD→ACC occurs on `out_valid&&out_ready`. On the same edge the accumulators are re-initialised:
  - `min1`, `min2` = all-ones magnitude.
  - `idx`, `cnt`, `sign` = 0.
- A single-beat row reports `min2` = all ones.
- Reset values: state ACC; `min1`, `min2` all ones; `idx`, `cnt`, `sign`, `trunc` 0; `out_valid=0`; `in_ready=1` (0 while `rst_n` is low).
- A reset mid-row or during HOLD discards the row and presents no output.

## Timing
- Result latency: the last beat is accepted at edge k, and `out_valid` is high from just after edge k.
- Throughput:
  - One beat per cycle within a row.
  - One bubble cycle per row: the HOLD cycle in which `out_ready` is sampled.
- Outputs stay stable while `out_valid && !out_ready`.
- `in_valid` may drop between beats; `cnt` advances only on an accepted beat.
- `in_ready` depends only on state and never combinationally on `out_ready`.

## Configuration
- `FP_CN_IN_PIPE_EN` defined:
  - Adds an input register stage (`data`, `last`, `valid`) ahead of the compare.
  - Result latency becomes k+1.
  - `in_ready` = ACC and the staged beat is not a closing beat.
  - Per-row bubble becomes two cycles.
  - Reset clears the stage.
- `FP_CN_IN_PIPE_EN` undefined: behaviour as above with zero extra stages.

## Structure
- Package `ldpc_fp_pkg`:
  - Default `EXP_W`/`MAN_W`.
  - State enum {ACC, HOLD}.
  - Helper function returning the all-ones magnitude for given widths.
- Sub-module `fp_mag_lt`: parametrised combinational unsigned `{exp,man}` less-than. It is instanced twice, for the min1 and min2 compares.

## Test plan
All vectors use defaults (EXP_W=8, MAN_W=23, DEG=6); hex values are full 32-bit words.
- Row {3F800000, BF000000, 40000000, 3E800000(last)} gives:
  - min1=3E800000, min2=3F000000, idx=3, sign=1, trunc=0.
  - `out_valid` rises right after the last beat's edge.
- Tie row {3F800000, 3F800000(last)} gives min1=min2=3F800000, idx=0, sign=0.
- Single beat {C0000000(last)} gives min1=40000000, min2=7FFFFFFF, idx=0, sign=1.
- Six beats 3F800000 with no `in_last` give:
  - Close after the sixth beat: trunc=1, idx=0.
  - A seventh offered beat is not accepted until after the out handshake.
- Backpressure and reset:
  - Holding `out_ready=0` for 5 cycles in HOLD keeps the outputs constant and `in_ready=0`.
  - Asserting `rst_n=0` for one cycle mid-row, then sending the row {3F000000(last)}, gives min1=3F000000, idx=0. No stale output appears.
- With `FP_CN_IN_PIPE_EN`: repeat the first scenario. The results are identical, and `out_valid` rises one cycle later.
